// File: rtl/tt_input_debouncer.sv
// Input conditioning for the Tiny Tapeout dedicated inputs.
// Each bit is synchronised, then debounced, then edge-detected into one-cycle pulses.
module tt_input_debouncer #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             changed_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [CNT_W-1:0] cnt_q  [WIDTH];
  logic [CNT_W-1:0] cnt_d  [WIDTH];
  logic [WIDTH-1:0] stable_s;
  logic [WIDTH-1:0] level_d;

  // Per-bit stability counter: any return to the accepted level restarts the count.
  always_comb begin
    stable_s = sync_q[SYNC_STAGES-1];
    level_d  = level_o;
    for (int b = 0; b < int'(WIDTH); b++) begin
      cnt_d[b] = cnt_q[b];
      if (stable_s[b] == level_o[b]) begin
        cnt_d[b] = '0;
      end else if (cnt_q[b] == CNT_LAST) begin
        level_d[b] = stable_s[b];
        cnt_d[b]   = '0;
      end else begin
        cnt_d[b] = cnt_q[b] + CNT_W'(1);
      end
    end
  end

  // Sync chain, counters, accepted level and edge pulses all share one reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) begin
        sync_q[k] <= '0;
      end
      for (int b = 0; b < int'(WIDTH); b++) begin
        cnt_q[b] <= '0;
      end
      level_o   <= '0;
      rise_o    <= '0;
      fall_o    <= '0;
      changed_o <= 1'b0;
    end else begin
      sync_q[0] <= raw_i;
      for (int k = 1; k < int'(SYNC_STAGES); k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      for (int b = 0; b < int'(WIDTH); b++) begin
        cnt_q[b] <= cnt_d[b];
      end
      level_o   <= level_d;
      rise_o    <= level_d & ~level_o;
      fall_o    <= ~level_d & level_o;
      changed_o <= (level_d != level_o);
    end
  end

endmodule

// File: tb/tb_tt_input_debouncer.sv
// Directed bench for tt_input_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4 (latency 6 edges).
module tb_tt_input_debouncer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] raw_i;
  logic [7:0] level_o;
  logic [7:0] rise_o;
  logic [7:0] fall_o;
  logic       changed_o;

  int checks = 0;
  int errors = 0;

  tt_input_debouncer #(
    .WIDTH(8),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .raw_i(raw_i),
    .level_o(level_o),
    .rise_o(rise_o),
    .fall_o(fall_o),
    .changed_o(changed_o)
  );

  always #5 clk = ~clk;

  // One active edge; returns on the following falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    raw_i = 8'h00;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (level_o !== 8'h00 || rise_o !== 8'h00 || fall_o !== 8'h00 || changed_o !== 1'b0) begin
      errors++;
      $display("FAIL reset: level=%h rise=%h fall=%h changed=%b, want all 0",
               level_o, rise_o, fall_o, changed_o);
    end
  endtask

  task automatic test_clean_step();
    logic [7:0] exp_level, exp_rise;
    do_reset();
    raw_i = 8'h01;
    for (int n = 1; n <= 9; n++) begin
      step();
      exp_level = (n >= 6) ? 8'h01 : 8'h00;
      exp_rise  = (n == 6) ? 8'h01 : 8'h00;
      checks++;
      if (level_o !== exp_level || rise_o !== exp_rise || fall_o !== 8'h00 ||
          changed_o !== (n == 6)) begin
        errors++;
        $display("FAIL clean_step edge %0d: level=%h rise=%h fall=%h changed=%b, want level=%h rise=%h fall=00 changed=%b",
                 n, level_o, rise_o, fall_o, changed_o, exp_level, exp_rise, (n == 6));
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    // Three-cycle pulse is one short of acceptance.
    for (int n = 1; n <= 12; n++) begin
      raw_i = (n <= 3) ? 8'h04 : 8'h00;
      step();
      checks++;
      if (level_o !== 8'h00 || rise_o !== 8'h00 || fall_o !== 8'h00 || changed_o !== 1'b0) begin
        errors++;
        $display("FAIL glitch edge %0d: level=%h rise=%h fall=%h changed=%b, want all 0",
                 n, level_o, rise_o, fall_o, changed_o);
      end
    end
    // Four-cycle pulse is accepted.
    for (int n = 1; n <= 6; n++) begin
      raw_i = (n <= 4) ? 8'h04 : 8'h00;
      step();
      checks++;
      if (level_o !== ((n == 6) ? 8'h04 : 8'h00) || rise_o !== ((n == 6) ? 8'h04 : 8'h00)) begin
        errors++;
        $display("FAIL glitch_accept edge %0d: level=%h rise=%h, want level=%h rise=%h",
                 n, level_o, rise_o, (n == 6) ? 8'h04 : 8'h00, (n == 6) ? 8'h04 : 8'h00);
      end
    end
  endtask

  task automatic test_bounce();
    logic pat [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int rises = 0;
    do_reset();
    // Final 0->1 is sampled at edge 6, so acceptance lands at edge 11.
    for (int n = 1; n <= 16; n++) begin
      raw_i = {7'd0, (n <= 9) ? pat[n-1] : 1'b1};
      step();
      if (rise_o[0] === 1'b1) rises++;
      checks++;
      if (level_o[0] !== (n >= 11) || rise_o[0] !== (n == 11) || fall_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL bounce edge %0d: level0=%b rise0=%b fall0=%b, want level0=%b rise0=%b fall0=0",
                 n, level_o[0], rise_o[0], fall_o[0], (n >= 11), (n == 11));
      end
    end
    checks++;
    if (rises != 1) begin
      errors++;
      $display("FAIL bounce_pulse_count: got %0d rise pulses, want 1", rises);
    end
  endtask

  task automatic test_release();
    do_reset();
    raw_i = 8'h0F;
    for (int n = 0; n < 8; n++) step();
    checks++;
    if (level_o !== 8'h0F) begin
      errors++;
      $display("FAIL release_setup: level=%h, want 0f", level_o);
    end
    raw_i = 8'h00;
    for (int n = 1; n <= 8; n++) begin
      step();
      checks++;
      if (level_o !== ((n >= 6) ? 8'h00 : 8'h0F) || fall_o !== ((n == 6) ? 8'h0F : 8'h00) ||
          rise_o !== 8'h00 || changed_o !== (n == 6)) begin
        errors++;
        $display("FAIL release edge %0d: level=%h rise=%h fall=%h changed=%b, want level=%h rise=00 fall=%h changed=%b",
                 n, level_o, rise_o, fall_o, changed_o, (n >= 6) ? 8'h00 : 8'h0F,
                 (n == 6) ? 8'h0F : 8'h00, (n == 6));
      end
    end
  endtask

  task automatic test_independent_bits();
    logic [7:0] exp_rise, exp_level;
    do_reset();
    for (int n = 1; n <= 10; n++) begin
      raw_i = (n >= 3) ? 8'h81 : 8'h01;
      step();
      exp_rise  = (n == 6) ? 8'h01 : ((n == 8) ? 8'h80 : 8'h00);
      exp_level = (n >= 8) ? 8'h81 : ((n >= 6) ? 8'h01 : 8'h00);
      checks++;
      if (rise_o !== exp_rise || level_o !== exp_level || changed_o !== (exp_rise != 8'h00)) begin
        errors++;
        $display("FAIL independent edge %0d: level=%h rise=%h changed=%b, want level=%h rise=%h changed=%b",
                 n, level_o, rise_o, changed_o, exp_level, exp_rise, (exp_rise != 8'h00));
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    raw_i = 8'hFF;
    for (int n = 0; n < 4; n++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (level_o !== 8'h00 || rise_o !== 8'h00 || fall_o !== 8'h00 || changed_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_clear: level=%h rise=%h fall=%h changed=%b, want all 0",
               level_o, rise_o, fall_o, changed_o);
    end
    // Full latency restarts after release; a retained count would accept early.
    for (int n = 1; n <= 8; n++) begin
      step();
      checks++;
      if (level_o !== ((n >= 6) ? 8'hFF : 8'h00) || rise_o !== ((n == 6) ? 8'hFF : 8'h00) ||
          changed_o !== (n == 6)) begin
        errors++;
        $display("FAIL mid_reset edge %0d: level=%h rise=%h changed=%b, want level=%h rise=%h changed=%b",
                 n, level_o, rise_o, changed_o, (n >= 6) ? 8'hFF : 8'h00,
                 (n == 6) ? 8'hFF : 8'h00, (n == 6));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    raw_i = 8'h00;
    @(negedge clk);
    test_reset();
    test_clean_step();
    test_glitch();
    test_bounce();
    test_release();
    test_independent_bits();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
